// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the 4-requester round-robin arbiter.
//   N_REQ  : number of requesters (fixed at 4)
//   IDX_W  : width of a requester index
//   state_t: arbiter FSM states (IDLE, GRANT)
//   req_t  : one bit per requester (request / one-hot grant vectors)
//   idx_t  : binary requester index
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Binary index to one-hot requester vector.
  function automatic req_t idx2oh(input idx_t i);
    req_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// -----------------------------------------------------------------------------
// arb4_rr_if
// Request/grant bus between the requesters and the arbiter.
//   req     : request per requester, held high while the resource is needed
//   gnt     : one-hot grant, zero when idle
//   gnt_idx : binary index of the owner, zero when idle
//   gnt_v   : any grant active (OR of gnt)
// Modports:
//   master : requester side (drives req, observes grant)
//   slave  : arbiter side (observes req, drives grant)
// -----------------------------------------------------------------------------
interface arb4_rr_if;
  import arb_pkg::*;

  req_t req;
  req_t gnt;
  idx_t gnt_idx;
  logic gnt_v;

  modport master (output req, input gnt, input gnt_idx, input gnt_v);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_v);

endinterface

// File: rtl/rr_prio_enc.sv
// -----------------------------------------------------------------------------
// rr_prio_enc
// Combinational rotating priority encoder. Searches the candidate vector
// (i_req with i_excl bits masked off) starting at i_ptr and wrapping around;
// the first set bit wins.
// Ports:
//   i_req  : request vector
//   i_ptr  : search start position
//   i_excl : requesters excluded from this search
//   o_idx  : winning index (0 when nothing is found)
//   o_vld  : a winner was found
// -----------------------------------------------------------------------------
module rr_prio_enc
  import arb_pkg::*;
(
  input  req_t i_req,
  input  idx_t i_ptr,
  input  req_t i_excl,
  output idx_t o_idx,
  output logic o_vld
);

  req_t w_cand;
  idx_t w_pos;

  assign w_cand = i_req & ~i_excl;

  // Walk from the farthest offset back to ptr so the nearest set bit is the
  // last one written and therefore wins.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    w_pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = i_ptr + idx_t'(k);
      if (w_cand[w_pos]) begin
        o_idx = w_pos;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// -----------------------------------------------------------------------------
// arb4_rr
// 4-requester round-robin arbiter. The owner keeps the grant while it keeps
// requesting; on release the grant moves directly to the next requester found
// from the round-robin pointer (no idle bubble). All outputs are registered.
// Grant index/valid match the 4-to-2 encoder format (2-bit index + valid).
// Parameters:
//   MAX_HOLD : max consecutive granted cycles before forced rotation
//              (only with ARB_TIMEOUT_EN), legal range 2..255
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : arb4_rr_if.slave (req in; gnt, gnt_idx, gnt_v out)
// Optional feature macro: ARB_TIMEOUT_EN enables the hold counter that forces
// rotation after MAX_HOLD cycles when another requester is waiting.
// -----------------------------------------------------------------------------
module arb4_rr
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  arb4_rr_if.slave   bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb4_rr: MAX_HOLD must be in 2..255");
  end

  state_t r_state;
  idx_t   r_ptr;
  req_t   r_gnt;
  idx_t   r_gnt_idx;
  logic   r_gnt_v;

  idx_t   w_pick_idx;
  logic   w_pick_v;
  logic   w_take;
  idx_t   w_take_idx;
  logic   w_release;

  // Normal pick: plain round-robin search over all current requests.
  rr_prio_enc u_pick (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .i_excl ('0),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_v)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  idx_t       w_tpick_idx;
  logic       w_tpick_v;

  // Timeout pick: same search with the current owner masked out.
  rr_prio_enc u_tpick (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .i_excl (r_gnt),
    .o_idx  (w_tpick_idx),
    .o_vld  (w_tpick_v)
  );
`endif

  // Next-grant decision. When the owner has dropped its bit, the normal pick
  // cannot select it, so the same pick serves both IDLE and handoff.
  always_comb begin
    w_take     = 1'b0;
    w_take_idx = w_pick_idx;
    w_release  = 1'b0;
    case (r_state)
      IDLE: w_take = w_pick_v;
      GRANT: begin
        if (bus.req[r_gnt_idx]) begin
`ifdef ARB_TIMEOUT_EN
          if (r_hold_cnt == HOLD_LAST && w_tpick_v) begin
            w_take     = 1'b1;
            w_take_idx = w_tpick_idx;
          end
`endif
        end else if (w_pick_v) begin
          w_take = 1'b1;
        end else begin
          w_release = 1'b1;
        end
      end
      default: w_release = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_gnt_v   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else if (w_take) begin
      r_state   <= GRANT;
      r_ptr     <= w_take_idx + idx_t'(1);
      r_gnt     <= idx2oh(w_take_idx);
      r_gnt_idx <= w_take_idx;
      r_gnt_v   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else if (w_release) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_gnt_v   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end
`ifdef ARB_TIMEOUT_EN
    // Owner holding: count up, saturating at the last allowed cycle.
    else if (r_state == GRANT && r_hold_cnt != HOLD_LAST) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
`endif
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_v   = r_gnt_v;

endmodule

// File: tb/tb_arb4_rr.sv
// -----------------------------------------------------------------------------
// tb_arb4_rr
// Directed bench for arb4_rr with hand-computed expected grants.
// Built with ARB_TIMEOUT_EN it also exercises forced rotation (MAX_HOLD=4).
// -----------------------------------------------------------------------------
module tb_arb4_rr;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  arb4_rr_if bus ();

  arb4_rr #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] e_gnt,
                         input logic [1:0] e_idx, input logic e_v);
    chk({tag, ".gnt"},     32'(bus.gnt),     32'(e_gnt));
    chk({tag, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(e_idx));
    chk({tag, ".gnt_v"},   32'(bus.gnt_v),   32'(e_v));
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e_gnt;
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    #1;

    // Reset with all requests pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bus("reset", 4'b0000, 2'd0, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    chk_bus("reset_release", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_bus("to_idle", 4'b0000, 2'd0, 1'b0);

    // Single holder for 10 cycles, then drop.
    bus.req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_bus("single_hold", 4'b0100, 2'd2, 1'b1);
    end
    bus.req = 4'b0000;
    tick();
    chk_bus("single_drop", 4'b0000, 2'd0, 1'b0);

    // Reset again so rotation starts from ptr=0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Handoff/rotation: each owner releases for one cycle after 3 cycles.
    bus.req = 4'b1111;
    tick();
    chk_bus("rot_first", 4'b0001, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      e_gnt = 4'b0001 << i;
      for (int c = 0; c < 2; c++) begin
        tick();
        chk_bus("rot_hold", e_gnt, 2'(i), 1'b1);
      end
      bus.req = 4'b1111 & ~e_gnt;
      tick();
      e_gnt = 4'b0001 << ((i + 1) % 4);
      chk_bus("rot_handoff", e_gnt, 2'((i + 1) % 4), 1'b1);
      bus.req = 4'b1111;
    end

    // Pointer fairness: owner 0 -> owner 1 -> idle leaves ptr=2.
    bus.req = 4'b0010;
    tick();
    chk_bus("fair_own1", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_bus("fair_idle", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b0011;
    tick();
    chk_bus("fair_pick", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_bus("fair_idle2", 4'b0000, 2'd0, 1'b0);

    // ptr=1 here, so requester 1 wins first with req=0011.
    bus.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 12; c++) begin
      tick();
      e_gnt = ((c / 4) % 2 == 0) ? 4'b0010 : 4'b0001;
      chk_bus("timeout_alt", e_gnt, ((c / 4) % 2 == 0) ? 2'd1 : 2'd0, 1'b1);
    end
`else
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_bus("no_timeout_hold", 4'b0010, 2'd1, 1'b1);
    end
`endif
    bus.req = 4'b0000;
    tick();
    chk_bus("two_req_idle", 4'b0000, 2'd0, 1'b0);

    // Lone owner keeps the grant indefinitely.
    bus.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_bus("lone_hold", 4'b0001, 2'd0, 1'b1);
    end
    bus.req = 4'b0000;
    tick();

    // Reset mid-grant with owner 3 still requesting.
    bus.req = 4'b1000;
    tick();
    chk_bus("own3", 4'b1000, 2'd3, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_bus("midgrant_reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_bus("midgrant_release", 4'b1000, 2'd3, 1'b1);
    // ptr is now 0; requester 0 must win over 3 after 3 releases.
    bus.req = 4'b0001;
    tick();
    chk_bus("after_reset_handoff", 4'b0001, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arb4_rr.md
Name: arb4_rr

Overview:
- 4-requester round-robin arbiter sharing one resource; grants are held while the owner keeps requesting.
- Grant index and valid use the same encoding as the 4-to-2 encoder (2-bit index plus valid), so it slots directly in front of the encoder-based datapath.
- All outputs are registered.
- Ownership change between requesters takes 1 cycle with no idle bubble.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 for this revision.
- MAX_HOLD, 8, maximum consecutive granted cycles before forced rotation; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  request per requester; a requester holds its bit high for as long as it needs the resource.
- gnt  output  4  one-hot grant; all zero when idle.
- gnt_idx  output  2  binary index of the owner; 0 when idle.
- gnt_v  output  1  high when any grant is active; equals OR of gnt.

Behaviour:
- Reset (rst_n=0 at a clk edge): gnt=0000, gnt_idx=00, gnt_v=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides everything, including mid-grant; req is ignored while in reset.
- ptr (2 bits) is the round-robin start position. The pick searches req at ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
- States:
  - IDLE: if req!=0, grant the pick at the next edge (latency 1 cycle from req sampled) and go to GRANT; else stay in IDLE.
  - GRANT, req[owner]=1: hold owner, gnt unchanged.
  - GRANT, req[owner]=0 and some other req set: grant the new pick at the next edge, stay in GRANT (direct handoff, no bubble).
  - GRANT, req[owner]=0 and req=0: gnt cleared at the next edge, go to IDLE.
- On every new grant to index k: ptr <= (k+1) mod 4.
- A grant is never given to a requester whose req bit is 0 at the sampling edge.
- Simultaneous owner release and new request: the new request participates in that same cycle's pick.
- Bus invariants: gnt is one-hot or zero; gnt_idx matches gnt; gnt_v=|gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bits) clears on each new grant and increments each GRANT cycle while the owner holds.
  - When hold_cnt=MAX_HOLD-1 and any other req bit is set, the next edge forces a grant to the pick among the other requesters (owner excluded), ptr updates as normal, and hold_cnt clears.
  - If no other requester is present, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Not defined: no hold_cnt logic; the owner keeps the grant indefinitely while req[owner]=1.

Decomposition:
- Package arb_pkg:
  - N_REQ=4 and IDX_W=2 constants.
  - State enum: IDLE, GRANT.
  - Typedefs req_t (logic[3:0]) and idx_t (logic[1:0]).
- Sub-module rr_prio_enc: combinational rotating priority encoder.
  - Inputs: req, ptr, exclude mask.
  - Outputs: pick index, pick valid.
  - Reused for both the normal pick and the timeout pick.

Test Plan:
- Reset: req=1111 with rst_n=0 for 3 cycles -> gnt=0000, gnt_v=0 throughout. Release -> one cycle later gnt=0001, gnt_idx=0.
- Single holder: req=0100 held 10 cycles -> gnt=0100, gnt_idx=2 from cycle 1 to cycle 10. Drop req -> gnt=0000, gnt_v=0 next cycle.
- Handoff/rotation: req=1111, each owner drops its bit for 1 cycle after 3 cycles of ownership -> grant order 0,1,2,3,0 with no gnt_v=0 cycles between owners.
- Pointer fairness: after owner 1 releases to idle (ptr=2), apply req=0011 -> gnt=0001 (search order 2,3,0), not 0010.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 constant -> gnt alternates 0001 and 0010 every 4 cycles. With req=0001 only -> gnt=0001 stays indefinitely.
- Reset mid-grant: owner 3 active, rst_n=0 for 1 cycle with req=1000 held -> gnt=0000 next edge. After release -> gnt=1000 (ptr reset to 0, search finds 3).
